phase_sequencer: RTL and testbench
==================================

// Module: phase_sequencer
// PURPOSE
//  Registered controller for the phase-based info protocol on {in1,in2}: 11 = give info,
//  01 = confirm info, 00 = end phase, 10 = idle separator. Stages data on GIVE and commits
//  it to diode on CONFIRM. Advances a wrapping phase counter on END, pulsing phaser_plus.
//  Sits between the external command pins and the diode/phase consumers.
// PARAMETERS
//  NUM_PHASES   8      phases per cycle; phase wraps NUM_PHASES-1 -> 0
//  PHASE_W      3      width of phase; must satisfy 2**PHASE_W >= NUM_PHASES
//  DATA_W       4      width of data, staged register and diode
//  WRITE_PHASE  0      only phase in which CONFIRM may commit to diode
//  RESET_DIODE  0      diode value after reset
// PORTS
//  clk          in   1        single clock; all state changes on rising edge
//  rst          in   1        synchronous, active-high reset
//  in1          in   1        command code MSB
//  in2          in   1        command code LSB
//  data         in   DATA_W   info word, sampled only on a GIVE command
//  phase        out  PHASE_W  current phase number
//  phaser_plus  out  1        one-cycle pulse: phase advanced this cycle
//  diode        out  DATA_W   last committed info word
//  confirm_ok   out  1        one-cycle pulse: CONFIRM committed staged data to diode
//  err          out  1        one-cycle pulse: protocol violation (see below)
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge): phase=0, phaser_plus=0, diode=RESET_DIODE, confirm_ok=0,
//    err=0, staged=0, state=IDLE, prev_code=2'b10. Reset wins over any command that cycle;
//    a reset mid-sequence discards staged data without committing it.
//  - Command detect: code={in1,in2}. A command fires only in a cycle where code != prev_code
//    (new-code edge). prev_code <= code every cycle. A held code fires exactly once.
//    Code 10 never fires anything.
//  - Latency: fired command sampled at edge N; all outputs reflect it after edge N
//    (1 cycle). Pulses are high for exactly that one cycle, otherwise 0.
//  - FSM states: IDLE (nothing staged), STAGED (data held, not committed), COMMITTED.
//    * GIVE(11), any state: staged<=data; state->STAGED. A second GIVE overwrites staged.
//    * CONFIRM(01), STAGED and phase==WRITE_PHASE: diode<=staged; confirm_ok=1;
//      state->COMMITTED.
//    * CONFIRM(01), STAGED and phase!=WRITE_PHASE: err=1; diode unchanged; stays STAGED.
//    * CONFIRM(01), IDLE or COMMITTED: err=1; no other change.
//    * END(00), any state: phaser_plus=1; phase<=(phase==NUM_PHASES-1)?0:phase+1;
//      staged<=0; state->IDLE. If state was STAGED, also err=1 (uncommitted data dropped).
//  - err and phaser_plus may pulse in the same cycle (END from STAGED).
//    confirm_ok and err never pulse in the same cycle.
//  - diode changes only via CONFIRM commit or reset; END does not clear diode.
//  - Phase arithmetic is unsigned modulo NUM_PHASES; no value >= NUM_PHASES is ever output.
// TESTING
//  1 Reset: assert rst 2 cycles with code=00 -> phase=0, diode=RESET_DIODE, no pulses;
//    first 00 seen after release still fires (prev_code=10).
//  2 Commit: phase=0, code 11 with data=4'hA, then 01 -> confirm_ok 1 cycle;
//    diode=4'hA one cycle after the 01 edge.
//  3 Hold: keep code 00 for 5 cycles -> phaser_plus exactly 1 pulse, phase 0->1.
//  4 Wrap: 8 END edges separated by code 10 -> phase 0..7 then 0; 8 phaser_plus pulses.
//  5 Errors: 01 with nothing staged -> err, diode unchanged. At phase=1, 11(data=3) then 01
//    -> err, diode unchanged. Then 00 -> err and phaser_plus same cycle, phase=2.
//  6 Reset mid-op: 11 with data=5, then rst during STAGED, then 01 -> err,
//    diode=RESET_DIODE.

Source files
------------

// File: rtl/phase_sequencer.sv
// -----------------------------------------------------------------------------
// phase_sequencer
//
// Registered controller for a two-pin command protocol on {in1,in2}:
//   11 = GIVE    : stage the data word
//   01 = CONFIRM : commit the staged word to diode (only in WRITE_PHASE)
//   00 = END     : advance the wrapping phase counter, drop staged data
//   10 = idle separator, never acts
// A command acts once, on the cycle its code first appears (edge on the code).
// All outputs are registered, so each one reflects a command one cycle after
// the clock edge that sampled it.
//
// Ports
//   clk          in   1        rising-edge clock
//   rst          in   1        synchronous, active-high reset
//   in1, in2     in   1        command code {MSB, LSB}
//   data         in   DATA_W   info word, sampled on GIVE
//   phase        out  PHASE_W  current phase, 0 .. NUM_PHASES-1
//   phaser_plus  out  1        one-cycle pulse: phase advanced
//   diode        out  DATA_W   last committed info word
//   confirm_ok   out  1        one-cycle pulse: CONFIRM committed
//   err          out  1        one-cycle pulse: protocol violation
// -----------------------------------------------------------------------------
module phase_sequencer #(
   parameter int                NUM_PHASES  = 8,
   parameter int                PHASE_W     = 3,
   parameter int                DATA_W      = 4,
   parameter int                WRITE_PHASE = 0,
   parameter logic [DATA_W-1:0] RESET_DIODE = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in1,
   input  logic               in2,
   input  logic [DATA_W-1:0]  data,
   output logic [PHASE_W-1:0] phase,
   output logic               phaser_plus,
   output logic [DATA_W-1:0]  diode,
   output logic               confirm_ok,
   output logic               err
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      STAGED    = 2'd1,
      COMMITTED = 2'd2
   } state_t;

   localparam logic [1:0] CODE_GIVE    = 2'b11;
   localparam logic [1:0] CODE_CONFIRM = 2'b01;
   localparam logic [1:0] CODE_END     = 2'b00;
   localparam logic [1:0] CODE_SEP     = 2'b10;

   localparam logic [PHASE_W-1:0] LAST_PHASE  = PHASE_W'(NUM_PHASES - 1);
   localparam logic [PHASE_W-1:0] WR_PHASE    = PHASE_W'(WRITE_PHASE);

   state_t             state_q;
   logic [1:0]         prev_code_q;
   logic [DATA_W-1:0]  staged_q;
   logic [PHASE_W-1:0] phase_q;
   logic [DATA_W-1:0]  diode_q;
   logic               phaser_plus_q;
   logic               confirm_ok_q;
   logic               err_q;

   logic [1:0]         code;
   logic               fire;
   logic [PHASE_W-1:0] phase_d;

   assign code = {in1, in2};
   // Only a change of code is a command; the separator code never acts, which
   // also makes it the natural post-reset value of prev_code_q.
   assign fire = (code != prev_code_q) && (code != CODE_SEP);
   // Explicit wrap so that no value >= NUM_PHASES is ever produced, even when
   // NUM_PHASES is not a power of two.
   assign phase_d = (phase_q == LAST_PHASE) ? '0 : phase_q + PHASE_W'(1);

   // NOTE: all state here is updated with non-blocking assignments so every
   // register samples the pre-edge values of the others, independent of
   // statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         prev_code_q   <= CODE_SEP;
         staged_q      <= '0;
         phase_q       <= '0;
         diode_q       <= RESET_DIODE;
         phaser_plus_q <= 1'b0;
         confirm_ok_q  <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         prev_code_q   <= code;
         // Pulses default low; a firing command raises them for one cycle.
         phaser_plus_q <= 1'b0;
         confirm_ok_q  <= 1'b0;
         err_q         <= 1'b0;
         if (fire) begin
            unique case (code)
               CODE_GIVE: begin
                  staged_q <= data;
                  state_q  <= STAGED;
               end
               CODE_CONFIRM: begin
                  if (state_q == STAGED && phase_q == WR_PHASE) begin
                     diode_q      <= staged_q;
                     confirm_ok_q <= 1'b1;
                     state_q      <= COMMITTED;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
               CODE_END: begin
                  phaser_plus_q <= 1'b1;
                  phase_q       <= phase_d;
                  staged_q      <= '0;
                  // Ending a phase with uncommitted data loses it.
                  err_q         <= (state_q == STAGED);
                  state_q       <= IDLE;
               end
               default: ;
            endcase
         end
      end
   end

   assign phase       = phase_q;
   assign phaser_plus = phaser_plus_q;
   assign diode       = diode_q;
   assign confirm_ok  = confirm_ok_q;
   assign err         = err_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// -----------------------------------------------------------------------------
// tb_phase_sequencer
//
// Drives directed scenarios followed by random command traffic. A behavioural
// model (phase counter, "data pending" flag, last code) predicts the outputs;
// a compare process checks every output on every falling edge once reset has
// been applied. Directed scenarios also pin absolute values.
// -----------------------------------------------------------------------------
module tb_phase_sequencer;

   localparam int NUM_PHASES  = 8;
   localparam int WRITE_PHASE = 0;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in1 = 1'b0;
   logic       in2 = 1'b0;
   logic [3:0] data = 4'h0;
   logic [2:0] phase;
   logic       phaser_plus;
   logic [3:0] diode;
   logic       confirm_ok;
   logic       err;

   phase_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .in1         (in1),
      .in2         (in2),
      .data        (data),
      .phase       (phase),
      .phaser_plus (phaser_plus),
      .diode       (diode),
      .confirm_ok  (confirm_ok),
      .err         (err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit check_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int       m_phase;
   int       m_diode;
   int       m_staged;
   bit       m_pending;   // data given and neither committed nor dropped
   int       m_prev;
   bit       m_pp, m_ok, m_err;

   always @(posedge clk) begin
      int c;
      c = {in1, in2};
      if (rst) begin
         m_phase = 0; m_diode = 0; m_staged = 0; m_pending = 0;
         m_prev = 2; m_pp = 0; m_ok = 0; m_err = 0;
      end else begin
         m_pp = 0; m_ok = 0; m_err = 0;
         if (c != m_prev) begin
            if (c == 3) begin
               m_staged = data; m_pending = 1;
            end else if (c == 1) begin
               if (m_pending && m_phase == WRITE_PHASE) begin
                  m_diode = m_staged; m_ok = 1; m_pending = 0;
               end else begin
                  m_err = 1;
               end
            end else if (c == 0) begin
               m_pp = 1;
               m_err = m_pending;
               m_phase = (m_phase + 1) % NUM_PHASES;
               m_staged = 0; m_pending = 0;
            end
         end
         m_prev = c;
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (check_en) begin
         check("phase",       32'(phase),       32'(m_phase));
         check("phaser_plus", 32'(phaser_plus), 32'(m_pp));
         check("diode",       32'(diode),       32'(m_diode));
         check("confirm_ok",  32'(confirm_ok),  32'(m_ok));
         check("err",         32'(err),         32'(m_err));
         check("phase_range", 32'(phase < NUM_PHASES), 32'(1));
         check("ok_err_excl", 32'(confirm_ok & err), 32'(0));
      end
   end

   // Apply inputs for one cycle; returns just after the edge that samples them.
   task automatic cyc(input logic r, input logic [1:0] c, input logic [3:0] d);
      @(negedge clk);
      rst = r; {in1, in2} = c; data = d;
      @(posedge clk);
      #1;
   endtask

   int pp_count;

   initial begin
      // 1: reset held 2 cycles with END code, then END held after release
      cyc(1'b1, 2'b00, 4'h0);
      cyc(1'b1, 2'b00, 4'h0);
      check_en = 1'b1;
      check("t1_phase", 32'(phase), 32'(0));
      check("t1_diode", 32'(diode), 32'(0));
      check("t1_pulses", 32'({phaser_plus, confirm_ok, err}), 32'(0));
      // 3: hold END for 5 cycles -> one pulse, phase 0->1
      pp_count = 0;
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0, 2'b00, 4'h0);
         if (i == 0) check("t1_first_end_fires", 32'(phaser_plus), 32'(1));
         pp_count += int'(phaser_plus);
      end
      check("t3_pp_count", 32'(pp_count), 32'(1));
      check("t3_phase", 32'(phase), 32'(1));

      // 2: commit at phase 0
      cyc(1'b1, 2'b10, 4'h0);
      cyc(1'b0, 2'b11, 4'hA);
      check("t2_no_ok_on_give", 32'(confirm_ok), 32'(0));
      cyc(1'b0, 2'b01, 4'h0);
      check("t2_ok", 32'(confirm_ok), 32'(1));
      check("t2_diode", 32'(diode), 32'hA);
      cyc(1'b0, 2'b01, 4'h0);
      check("t2_ok_one_cycle", 32'(confirm_ok), 32'(0));

      // 4: wrap with 8 END edges separated by the idle code
      cyc(1'b0, 2'b10, 4'h0);
      pp_count = 0;
      for (int i = 0; i < 8; i++) begin
         cyc(1'b0, 2'b00, 4'h0);
         pp_count += int'(phaser_plus);
         check("t4_phase", 32'(phase), 32'((i + 1) % 8));
         cyc(1'b0, 2'b10, 4'h0);
      end
      check("t4_pp_count", 32'(pp_count), 32'(8));
      check("t4_diode_kept", 32'(diode), 32'hA);

      // 5: error cases
      cyc(1'b0, 2'b01, 4'h0);
      check("t5_err_idle", 32'(err), 32'(1));
      check("t5_diode_idle", 32'(diode), 32'hA);
      cyc(1'b0, 2'b00, 4'h0);
      check("t5_phase1", 32'(phase), 32'(1));
      cyc(1'b0, 2'b11, 4'h3);
      cyc(1'b0, 2'b01, 4'h0);
      check("t5_err_wrong_phase", 32'(err), 32'(1));
      check("t5_no_ok", 32'(confirm_ok), 32'(0));
      check("t5_diode_wrong_phase", 32'(diode), 32'hA);
      cyc(1'b0, 2'b00, 4'h0);
      check("t5_err_drop", 32'(err), 32'(1));
      check("t5_pp_drop", 32'(phaser_plus), 32'(1));
      check("t5_phase2", 32'(phase), 32'(2));

      // 6: reset while staged, then confirm
      cyc(1'b0, 2'b11, 4'h5);
      cyc(1'b1, 2'b11, 4'h5);
      cyc(1'b0, 2'b01, 4'h0);
      check("t6_err", 32'(err), 32'(1));
      check("t6_diode", 32'(diode), 32'(0));
      check("t6_phase", 32'(phase), 32'(0));

      // Random traffic; the idle code is weighted up so edges are frequent
      // and rare resets exercise mid-sequence recovery.
      for (int i = 0; i < 3000; i++) begin
         logic       r;
         logic [1:0] c;
         r = ($urandom_range(0, 99) == 0);
         c = 2'($urandom_range(0, 4));
         if (c == 2'b00 && $urandom_range(0, 1) == 1) c = 2'b10;
         cyc(r, c, 4'($urandom));
      end

      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
